bbox_frame_ctrl: RTL and testbench

BBOX_FRAME_CTRL -- requirements
Module: bbox_frame_ctrl

---
 rtl/bbox_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_bbox_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_frame_ctrl.sv
// Frame-synchronous bounding-box latch: waits for coordinates to settle after endframe,
// validates and holds the box across a limited run of bad frames, and flags outline pixels.
module bbox_frame_ctrl #(
  parameter int SETTLE_CYCLES = 143,
  parameter int HOLD_FRAMES   = 4,
  parameter int NO_COORD      = 641
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        endframe,
  input  logic [9:0]  min_x,
  input  logic [9:0]  max_x,
  input  logic [9:0]  min_y,
  input  logic [9:0]  max_y,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  output logic        frame_ack,
  output logic        box_valid,
  output logic [9:0]  box_min_x,
  output logic [9:0]  box_max_x,
  output logic [9:0]  box_min_y,
  output logic [9:0]  box_max_y,
  output logic        overlay_hit,
  output logic [2:0]  miss_count,
  output logic [15:0] frame_count
);

  localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [9:0]      NC       = 10'(NO_COORD);
  localparam logic [2:0]      HOLD     = 3'(HOLD_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LATCH, S_ACK} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ef_prev;
  logic             r_armed;
  logic             w_edge;
  logic             w_latch;
  logic             w_ack;
  logic             w_frame_ok;
  logic [2:0]       w_miss_nxt;

  logic        r_box_valid;
  logic [9:0]  r_box_min_x, r_box_max_x, r_box_min_y, r_box_max_y;
  logic [2:0]  r_miss;
  logic [15:0] r_fcnt;
  logic        r_hit;

  function automatic logic f_frame_ok(input logic [9:0] mnx, input logic [9:0] mxx,
                                      input logic [9:0] mny, input logic [9:0] mxy);
    return (mnx != NC) && (mny != NC) && (mnx <= mxx) && (mny <= mxy) &&
           (mxx <= 10'd639) && (mxy <= 10'd479);
  endfunction

  function automatic logic [2:0] f_miss_sat_inc(input logic [2:0] m);
    return (m >= HOLD) ? HOLD : m + 3'd1;
  endfunction

  function automatic logic f_on_outline(input logic [9:0] x, input logic [9:0] y);
    logic w_row, w_col;
    w_row = ((y == r_box_min_y) || (y == r_box_max_y)) && (x >= r_box_min_x) && (x <= r_box_max_x);
    w_col = ((x == r_box_min_x) || (x == r_box_max_x)) && (y >= r_box_min_y) && (y <= r_box_max_y);
    return r_box_valid && (w_row || w_col);
  endfunction

  // Edge detect; r_armed blocks a level that was already high when reset released
  assign w_edge = endframe & ~r_ef_prev & r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ef_prev <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_ef_prev <= endframe;
      if (!endframe) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != S_SETTLE)) r_cnt <= '0;
    else                                r_cnt <= r_cnt + CNT_W'(1);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_edge) w_next = S_SETTLE;
      S_SETTLE: begin
        if (!endframe)             w_next = S_IDLE;
        else if (r_cnt == CNT_LAST) w_next = S_LATCH;
      end
      S_LATCH:  w_next = S_ACK;
      S_ACK:    if (!endframe) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch = (r_state == S_LATCH);
    w_ack   = (r_state == S_ACK);
  end

  assign w_frame_ok = f_frame_ok(min_x, max_x, min_y, max_y);
  assign w_miss_nxt = f_miss_sat_inc(r_miss);

  // Latch stage: accepted box or miss bookkeeping, visible the cycle after LATCH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_box_valid <= 1'b0;
      r_box_min_x <= NC;
      r_box_max_x <= NC;
      r_box_min_y <= NC;
      r_box_max_y <= NC;
      r_miss      <= 3'd0;
      r_fcnt      <= 16'd0;
    end else if (w_latch) begin
      r_fcnt <= r_fcnt + 16'd1;
      if (w_frame_ok) begin
        r_box_valid <= 1'b1;
        r_box_min_x <= min_x;
        r_box_max_x <= max_x;
        r_box_min_y <= min_y;
        r_box_max_y <= max_y;
        r_miss      <= 3'd0;
      end else begin
        r_miss <= w_miss_nxt;
        if (w_miss_nxt == HOLD) begin
          r_box_valid <= 1'b0;
          r_box_min_x <= NC;
          r_box_max_x <= NC;
          r_box_min_y <= NC;
          r_box_max_y <= NC;
        end
      end
    end
  end

  // Overlay stage: one cycle behind drawX/drawY against the live box
  always_ff @(posedge clk) begin
    if (reset) r_hit <= 1'b0;
    else       r_hit <= f_on_outline(drawX, drawY);
  end

  assign frame_ack   = w_ack;
  assign box_valid   = r_box_valid;
  assign box_min_x   = r_box_min_x;
  assign box_max_x   = r_box_max_x;
  assign box_min_y   = r_box_min_y;
  assign box_max_y   = r_box_max_y;
  assign overlay_hit = r_hit;
  assign miss_count  = r_miss;
  assign frame_count = r_fcnt;

endmodule

// File: tb/tb_bbox_frame_ctrl.sv
// Bench for bbox_frame_ctrl: table-driven frames and overlay points, multi-cycle corner
// sequences, and randomized frames checked against a frame-level reference model.
module tb_bbox_frame_ctrl;

  localparam int SC   = 143;
  localparam int HOLD = 4;
  localparam int NC   = 641;

  logic        clk = 1'b0;
  logic        reset;
  logic        endframe;
  logic [9:0]  min_x, max_x, min_y, max_y, drawX, drawY;
  logic        frame_ack, box_valid, overlay_hit;
  logic [9:0]  box_min_x, box_max_x, box_min_y, box_max_y;
  logic [2:0]  miss_count;
  logic [15:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_b[4];
  bit m_valid;
  int m_miss;
  int m_fc;

  typedef struct {
    logic [9:0] mnx, mxx, mny, mxy;
    logic       e_valid;
    logic [2:0] e_miss;
    logic [9:0] e_b0, e_b1, e_b2, e_b3;
  } frame_vec_t;

  typedef struct {
    logic [9:0] x, y;
    logic       e_hit;
  } draw_vec_t;

  frame_vec_t fv[12];
  draw_vec_t  dv[11];

  bbox_frame_ctrl #(.SETTLE_CYCLES(SC), .HOLD_FRAMES(HOLD), .NO_COORD(NC)) dut (
    .clk(clk), .reset(reset), .endframe(endframe),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
    .drawX(drawX), .drawY(drawY),
    .frame_ack(frame_ack), .box_valid(box_valid),
    .box_min_x(box_min_x), .box_max_x(box_max_x), .box_min_y(box_min_y), .box_max_y(box_max_y),
    .overlay_hit(overlay_hit), .miss_count(miss_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_b[i] = NC;
    m_valid = 0;
    m_miss  = 0;
    m_fc    = 0;
  endtask

  task automatic model_frame(input int a, input int b, input int c, input int d);
    bit ok;
    ok = (a != NC) && (c != NC) && (a <= b) && (c <= d) && (b <= 639) && (d <= 479);
    if (ok) begin
      m_b[0] = a; m_b[1] = b; m_b[2] = c; m_b[3] = d;
      m_valid = 1;
      m_miss  = 0;
    end else begin
      m_miss = (m_miss < HOLD) ? m_miss + 1 : HOLD;
      if (m_miss == HOLD) begin
        m_valid = 0;
        for (int i = 0; i < 4; i++) m_b[i] = NC;
      end
    end
    m_fc = (m_fc + 1) % 65536;
  endtask

  function automatic bit model_hit(input int x, input int y);
    if (!m_valid) return 0;
    return (((y == m_b[2]) || (y == m_b[3])) && (m_b[0] <= x) && (x <= m_b[1])) ||
           (((x == m_b[0]) || (x == m_b[1])) && (m_b[2] <= y) && (y <= m_b[3]));
  endfunction

  // Raise endframe with coordinates, wait for the ack and check its latency
  task automatic start_frame(input logic [9:0] a, input logic [9:0] b,
                             input logic [9:0] c, input logic [9:0] d);
    int ack_tick;
    min_x = a; max_x = b; min_y = c; max_y = d;
    endframe = 1'b1;
    ack_tick = 0;
    for (int t = 1; t <= 400; t++) begin
      tick();
      if (frame_ack) begin
        ack_tick = t;
        break;
      end
    end
    check("ack_latency", ack_tick, SC + 2);
    model_frame(a, b, c, d);
  endtask

  task automatic finish_frame();
    tick();
    check("ack_held_while_endframe_high", frame_ack, 1);
    endframe = 1'b0;
    tick();
    check("ack_drop_after_endframe_low", frame_ack, 0);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_box_valid"},   box_valid,   m_valid);
    check({tag, "_miss_count"},  miss_count,  m_miss);
    check({tag, "_frame_count"}, frame_count, m_fc);
    check({tag, "_box_min_x"},   box_min_x,   m_b[0]);
    check({tag, "_box_max_x"},   box_max_x,   m_b[1]);
    check({tag, "_box_min_y"},   box_min_y,   m_b[2]);
    check({tag, "_box_max_y"},   box_max_y,   m_b[3]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_frame_ack"},   frame_ack,   0);
    check({tag, "_box_valid"},   box_valid,   0);
    check({tag, "_box_min_x"},   box_min_x,   NC);
    check({tag, "_box_max_x"},   box_max_x,   NC);
    check({tag, "_box_min_y"},   box_min_y,   NC);
    check({tag, "_box_max_y"},   box_max_y,   NC);
    check({tag, "_overlay_hit"}, overlay_hit, 0);
    check({tag, "_miss_count"},  miss_count,  0);
    check({tag, "_frame_count"}, frame_count, 0);
  endtask

  function automatic int pick_coord(input int lo, input int hi);
    case ($urandom_range(0, 4))
      0: return lo;
      1: return hi;
      2: return (lo - 1) & 10'h3FF;
      3: return (hi + 1) & 10'h3FF;
      default: return $urandom_range(0, 700);
    endcase
  endfunction

  initial begin
    int a, b, c, d, kind, x, y;
    bit seen_ack;

    fv[0]  = '{10'd100, 10'd200, 10'd50, 10'd150, 1'b1, 3'd0, 10'd100, 10'd200, 10'd50, 10'd150};
    fv[1]  = '{10'd641, 10'd200, 10'd50, 10'd150, 1'b1, 3'd1, 10'd100, 10'd200, 10'd50, 10'd150};
    fv[2]  = '{10'd641, 10'd200, 10'd50, 10'd150, 1'b1, 3'd2, 10'd100, 10'd200, 10'd50, 10'd150};
    fv[3]  = '{10'd641, 10'd200, 10'd50, 10'd150, 1'b1, 3'd3, 10'd100, 10'd200, 10'd50, 10'd150};
    fv[4]  = '{10'd641, 10'd200, 10'd50, 10'd150, 1'b0, 3'd4, 10'd641, 10'd641, 10'd641, 10'd641};
    fv[5]  = '{10'd300, 10'd200, 10'd50, 10'd150, 1'b0, 3'd4, 10'd641, 10'd641, 10'd641, 10'd641};
    fv[6]  = '{10'd100, 10'd200, 10'd50, 10'd150, 1'b1, 3'd0, 10'd100, 10'd200, 10'd50, 10'd150};
    fv[7]  = '{10'd300, 10'd200, 10'd50, 10'd150, 1'b1, 3'd1, 10'd100, 10'd200, 10'd50, 10'd150};
    fv[8]  = '{10'd0,   10'd639, 10'd0,  10'd479, 1'b1, 3'd0, 10'd0,   10'd639, 10'd0,  10'd479};
    fv[9]  = '{10'd0,   10'd640, 10'd0,  10'd479, 1'b1, 3'd1, 10'd0,   10'd639, 10'd0,  10'd479};
    fv[10] = '{10'd5,   10'd5,   10'd7,  10'd7,   1'b1, 3'd0, 10'd5,   10'd5,   10'd7,  10'd7};
    fv[11] = '{10'd10,  10'd20,  10'd641, 10'd700, 1'b1, 3'd1, 10'd5,  10'd5,   10'd7,  10'd7};

    dv[0]  = '{10'd100, 10'd80,  1'b1};
    dv[1]  = '{10'd150, 10'd80,  1'b0};
    dv[2]  = '{10'd150, 10'd50,  1'b1};
    dv[3]  = '{10'd150, 10'd150, 1'b1};
    dv[4]  = '{10'd200, 10'd150, 1'b1};
    dv[5]  = '{10'd201, 10'd150, 1'b0};
    dv[6]  = '{10'd99,  10'd50,  1'b0};
    dv[7]  = '{10'd100, 10'd49,  1'b0};
    dv[8]  = '{10'd100, 10'd151, 1'b0};
    dv[9]  = '{10'd200, 10'd100, 1'b1};
    dv[10] = '{10'd150, 10'd100, 1'b0};

    reset = 1'b1; endframe = 1'b0;
    min_x = '0; max_x = '0; min_y = '0; max_y = '0; drawX = '0; drawY = '0;
    model_reset();
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      start_frame(fv[i].mnx, fv[i].mxx, fv[i].mny, fv[i].mxy);
      check($sformatf("vec%0d_box_valid", i),   box_valid,   fv[i].e_valid);
      check($sformatf("vec%0d_miss_count", i),  miss_count,  fv[i].e_miss);
      check($sformatf("vec%0d_frame_count", i), frame_count, i + 1);
      check($sformatf("vec%0d_box_min_x", i),   box_min_x,   fv[i].e_b0);
      check($sformatf("vec%0d_box_max_x", i),   box_max_x,   fv[i].e_b1);
      check($sformatf("vec%0d_box_min_y", i),   box_min_y,   fv[i].e_b2);
      check($sformatf("vec%0d_box_max_y", i),   box_max_y,   fv[i].e_b3);
      finish_frame();
      if (i == 7) begin
        for (int k = 0; k < 11; k++) begin
          drawX = dv[k].x; drawY = dv[k].y;
          tick();
          check($sformatf("draw%0d_overlay_hit", k), overlay_hit, dv[k].e_hit);
        end
      end
    end

    // Endframe drops part way through settling: nothing may change
    endframe = 1'b1;
    repeat (50) tick();
    endframe = 1'b0;
    seen_ack = 0;
    for (int t = 0; t < SC + 10; t++) begin
      tick();
      if (frame_ack) seen_ack = 1;
    end
    check("abort_no_ack", seen_ack, 0);
    check_model("abort");

    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(0, 6);
      a = $urandom_range(0, 639); b = $urandom_range(a, 639);
      c = $urandom_range(0, 479); d = $urandom_range(c, 479);
      case (kind)
        3: a = NC;
        4: begin a = $urandom_range(1, 639); b = $urandom_range(0, a - 1); end
        5: d = $urandom_range(480, 1023);
        6: begin a = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
                 c = $urandom_range(0, 1023); d = $urandom_range(0, 1023); end
        default: ;
      endcase
      start_frame(10'(a), 10'(b), 10'(c), 10'(d));
      check_model($sformatf("rand%0d", f));
      finish_frame();
      for (int k = 0; k < 6; k++) begin
        x = pick_coord(m_b[0], m_b[1]);
        y = pick_coord(m_b[2], m_b[3]);
        drawX = 10'(x); drawY = 10'(y);
        tick();
        check($sformatf("rand%0d_hit%0d", f, k), overlay_hit, model_hit(x, y));
      end
    end

    // Reset while acknowledging, with endframe held high across release
    start_frame(10'd100, 10'd200, 10'd50, 10'd150);
    drawX = 10'd100; drawY = 10'd80;
    reset = 1'b1;
    tick();
    check_reset_values("ack_reset");
    reset = 1'b0;
    model_reset();
    seen_ack = 0;
    for (int t = 0; t < 2 * SC + 10; t++) begin
      tick();
      if (frame_ack) seen_ack = 1;
    end
    check("held_endframe_no_ack", seen_ack, 0);
    check("held_endframe_frame_count", frame_count, 0);
    check("held_endframe_box_valid", box_valid, 0);
    endframe = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
